// File: rtl/vliw_regfile_sb_if.sv
// Bus bundle for vliw_regfile_sb: read ports, write ports, issue and conflict report.
// master = decode/issue + execution lanes side, slave = register file.
interface vliw_regfile_sb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned LANES  = 4
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [LANES*2*AW-1:0]     rd_addr;
    logic [LANES*2*DATA_W-1:0] rd_data;
    logic [LANES*2-1:0]        rd_busy;
    logic [LANES-1:0]          wr_en;
    logic [LANES*AW-1:0]       wr_addr;
    logic [LANES*DATA_W-1:0]   wr_data;
    logic [LANES-1:0]          issue_en;
    logic [LANES*AW-1:0]       issue_rd;
    logic                      wr_conflict;
    logic [AW-1:0]             conflict_addr;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd,
        input  rd_data, rd_busy, wr_conflict, conflict_addr
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd,
        output rd_data, rd_busy, wr_conflict, conflict_addr
    );
endinterface

// File: rtl/vliw_regfile_sb.sv
// Multi-lane register file with pending-write scoreboard and write-collision report.
// Optional same-cycle write-to-read forwarding when RF_BYPASS_EN is defined.
module vliw_regfile_sb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned LANES  = 4
) (
    input logic               clk,
    input logic               rst,
    vliw_regfile_sb_if.slave  rf
);
    localparam int unsigned AW = $clog2(NREGS);
    localparam int unsigned NP = 2 * LANES;

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [NREGS-1:0]  r_pending;
    logic              r_conflict;
    logic [AW-1:0]     r_conflict_addr;

    logic [AW-1:0]     w_wr_addr   [LANES];
    logic [DATA_W-1:0] w_wr_data   [LANES];
    logic [LANES-1:0]  w_wr_valid;
    logic [AW-1:0]     w_issue_addr [LANES];
    logic [LANES-1:0]  w_issue_valid;

    logic [NREGS-1:0]  w_commit_en;
    logic [DATA_W-1:0] w_commit_data [NREGS];
    logic [NREGS-1:0]  w_issue_set;
    logic              w_conflict;
    logic [AW-1:0]     w_conflict_addr;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_wr_addr[l]     = rf.wr_addr[l*AW +: AW];
        assign w_wr_data[l]     = rf.wr_data[l*DATA_W +: DATA_W];
        assign w_wr_valid[l]    = rf.wr_en[l] && (w_wr_addr[l] != '0);
        assign w_issue_addr[l]  = rf.issue_rd[l*AW +: AW];
        assign w_issue_valid[l] = rf.issue_en[l] && (w_issue_addr[l] != '0);
    end

    // Ascending lane order: the highest-index lane on a shared address wins.
    always_comb begin
        w_commit_en = '0;
        w_issue_set = '0;
        for (int r = 0; r < NREGS; r++) begin
            w_commit_data[r] = '0;
        end
        for (int l = 0; l < LANES; l++) begin
            if (w_wr_valid[l]) begin
                w_commit_en[w_wr_addr[l]]   = 1'b1;
                w_commit_data[w_wr_addr[l]] = w_wr_data[l];
            end
            if (w_issue_valid[l]) begin
                w_issue_set[w_issue_addr[l]] = 1'b1;
            end
        end
    end

    always_comb begin
        w_conflict      = 1'b0;
        w_conflict_addr = '0;
        for (int i = 0; i < LANES; i++) begin
            for (int j = i + 1; j < LANES; j++) begin
                if (w_wr_valid[i] && w_wr_valid[j] && (w_wr_addr[i] == w_wr_addr[j])) begin
                    if (!w_conflict || (w_wr_addr[i] < w_conflict_addr)) begin
                        w_conflict      = 1'b1;
                        w_conflict_addr = w_wr_addr[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                r_regs[r] <= '0;
            end
            r_pending       <= '0;
            r_conflict      <= 1'b0;
            r_conflict_addr <= '0;
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (w_commit_en[r]) begin
                    r_regs[r] <= w_commit_data[r];
                end
            end
            // A same-cycle issue is a newer producer, so set beats clear.
            r_pending       <= (r_pending & ~w_commit_en) | w_issue_set;
            r_conflict      <= w_conflict;
            r_conflict_addr <= w_conflict_addr;
        end
    end

    assign rf.wr_conflict   = r_conflict;
    assign rf.conflict_addr = r_conflict_addr;

    for (genvar p = 0; p < NP; p++) begin : g_rd
        logic [AW-1:0]     w_a;
        logic [DATA_W-1:0] w_arr;
        assign w_a   = rf.rd_addr[p*AW +: AW];
        assign w_arr = (w_a == '0) ? '0 : r_regs[w_a];
`ifdef RF_BYPASS_EN
        logic w_fwd;
        assign w_fwd = !rst && w_commit_en[w_a];
        assign rf.rd_data[p*DATA_W +: DATA_W] = w_fwd ? w_commit_data[w_a] : w_arr;
        assign rf.rd_busy[p] = r_pending[w_a] && !w_fwd;
`else
        assign rf.rd_data[p*DATA_W +: DATA_W] = w_arr;
        assign rf.rd_busy[p] = r_pending[w_a];
`endif
    end

endmodule

// File: tb/tb_vliw_regfile_sb.sv
// Directed bench for vliw_regfile_sb; expectations follow RF_BYPASS_EN when defined.
module tb_vliw_regfile_sb;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned LANES  = 4;
    localparam int unsigned AW     = 5;
    localparam int unsigned NP     = 2 * LANES;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    vliw_regfile_sb_if #(.DATA_W(DATA_W), .NREGS(NREGS), .LANES(LANES)) rf_if ();

    vliw_regfile_sb #(.DATA_W(DATA_W), .NREGS(NREGS), .LANES(LANES)) dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf_if)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_in();
        rf_if.rd_addr  = '0;
        rf_if.wr_en    = '0;
        rf_if.wr_addr  = '0;
        rf_if.wr_data  = '0;
        rf_if.issue_en = '0;
        rf_if.issue_rd = '0;
    endtask

    task automatic clear_wr_issue();
        rf_if.wr_en    = '0;
        rf_if.wr_addr  = '0;
        rf_if.wr_data  = '0;
        rf_if.issue_en = '0;
        rf_if.issue_rd = '0;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rf_if.rd_addr[p*AW +: AW] = a;
    endtask

    task automatic set_wr(input int l, input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
        rf_if.wr_en[l]               = 1'b1;
        rf_if.wr_addr[l*AW +: AW]    = a;
        rf_if.wr_data[l*DATA_W +: DATA_W] = d;
    endtask

    task automatic set_issue(input int l, input logic [AW-1:0] a);
        rf_if.issue_en[l]          = 1'b1;
        rf_if.issue_rd[l*AW +: AW] = a;
    endtask

    function automatic logic [DATA_W-1:0] rdd(input int p);
        return rf_if.rd_data[p*DATA_W +: DATA_W];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state: every port reads 0 and is not busy.
        for (int p = 0; p < NP; p++) set_rd(p, AW'(p * 3));
        settle();
        for (int p = 0; p < NP; p++) begin
            check($sformatf("reset_data_p%0d", p), 64'(rdd(p)), 64'h0);
            check($sformatf("reset_busy_p%0d", p), 64'(rf_if.rd_busy[p]), 64'h0);
        end
        check("reset_conflict", 64'(rf_if.wr_conflict), 64'h0);
        check("reset_conf_addr", 64'(rf_if.conflict_addr), 64'h0);

        // Lane 1 writes r5; port 0 reads r0, others read r5.
        tick();
        set_rd(0, 5'd0);
        for (int p = 1; p < NP; p++) set_rd(p, 5'd5);
        set_wr(1, 5'd5, 32'hDEADBEEF);
        settle();
        check("r5_write_cycle", 64'(rdd(1)), BYP ? 64'hDEADBEEF : 64'h0);
        tick();
        clear_wr_issue();
        settle();
        check("r0_reads_zero", 64'(rdd(0)), 64'h0);
        for (int p = 1; p < NP; p++)
            check($sformatf("r5_p%0d", p), 64'(rdd(p)), 64'hDEADBEEF);

        // r0 write and issue are dropped.
        set_wr(0, 5'd0, 32'h1234);
        set_issue(1, 5'd0);
        tick();
        clear_wr_issue();
        settle();
        check("r0_after_write", 64'(rdd(0)), 64'h0);
        check("r0_busy", 64'(rf_if.rd_busy[0]), 64'h0);
        check("r0_no_conflict", 64'(rf_if.wr_conflict), 64'h0);

        // Lanes 0 and 2 collide on r7; lane 2 wins.
        set_rd(2, 5'd7);
        set_wr(0, 5'd7, 32'hAAAA);
        set_wr(2, 5'd7, 32'hBBBB);
        tick();
        clear_wr_issue();
        settle();
        check("r7_winner", 64'(rdd(2)), 64'hBBBB);
        check("r7_conflict", 64'(rf_if.wr_conflict), 64'h1);
        check("r7_conf_addr", 64'(rf_if.conflict_addr), 64'h7);
        tick();
        check("r7_conflict_drop", 64'(rf_if.wr_conflict), 64'h0);
        check("r7_conf_addr_drop", 64'(rf_if.conflict_addr), 64'h0);

        // Two collisions at once: r12 (lanes 0,1) and r10 (lanes 2,3); lowest address reported.
        set_rd(3, 5'd12);
        set_rd(4, 5'd10);
        set_wr(0, 5'd12, 32'h1200);
        set_wr(1, 5'd12, 32'h1201);
        set_wr(2, 5'd10, 32'h1002);
        set_wr(3, 5'd10, 32'h1003);
        tick();
        clear_wr_issue();
        settle();
        check("dual_conflict", 64'(rf_if.wr_conflict), 64'h1);
        check("dual_conf_addr", 64'(rf_if.conflict_addr), 64'd10);
        check("r12_winner", 64'(rdd(3)), 64'h1201);
        check("r10_winner", 64'(rdd(4)), 64'h1003);

        // Issue r9 on lane 3, then clear it with a lane 3 write.
        set_rd(0, 5'd9);
        set_rd(5, 5'd9);
        set_issue(3, 5'd9);
        settle();
        check("r9_busy_issue_cycle", 64'(rf_if.rd_busy[0]), 64'h0);
        tick();
        clear_wr_issue();
        settle();
        check("r9_busy_p0", 64'(rf_if.rd_busy[0]), 64'h1);
        check("r9_busy_p5", 64'(rf_if.rd_busy[5]), 64'h1);
        set_wr(3, 5'd9, 32'h99);
        settle();
        check("r9_busy_write_cycle", 64'(rf_if.rd_busy[0]), BYP ? 64'h0 : 64'h1);
        tick();
        clear_wr_issue();
        settle();
        check("r9_busy_after", 64'(rf_if.rd_busy[0]), 64'h0);
        check("r9_data", 64'(rdd(5)), 64'h99);

        // Same-cycle issue and write of r4: stays pending, data updates.
        set_rd(1, 5'd4);
        set_issue(1, 5'd4);
        set_wr(0, 5'd4, 32'h44);
        tick();
        clear_wr_issue();
        settle();
        check("r4_pending", 64'(rf_if.rd_busy[1]), 64'h1);
        check("r4_data", 64'(rdd(1)), 64'h44);

        // Read/write r3 in the same cycle.
        set_rd(6, 5'd3);
        set_wr(2, 5'd3, 32'h11);
        tick();
        clear_wr_issue();
        set_wr(2, 5'd3, 32'h55);
        settle();
        check("r3_same_cycle", 64'(rdd(6)), BYP ? 64'h55 : 64'h11);
        tick();
        clear_wr_issue();
        settle();
        check("r3_next_cycle", 64'(rdd(6)), 64'h55);

        // Reset with writes, issues and a collision active.
        set_rd(0, 5'd6);
        set_rd(2, 5'd11);
        set_rd(7, 5'd8);
        set_wr(0, 5'd6, 32'h66);
        set_wr(1, 5'd11, 32'hB1);
        set_wr(2, 5'd11, 32'hB2);
        set_issue(3, 5'd8);
        rst = 1'b1;
        settle();
        check("rst_cycle_r6_nobypass", 64'(rdd(0)), 64'h0);
        check("rst_cycle_r4_array", 64'(rdd(1)), 64'h44);
        tick();
        rst = 1'b0;
        clear_wr_issue();
        settle();
        check("post_rst_r6", 64'(rdd(0)), 64'h0);
        check("post_rst_r4", 64'(rdd(1)), 64'h0);
        check("post_rst_r4_busy", 64'(rf_if.rd_busy[1]), 64'h0);
        check("post_rst_r8_busy", 64'(rf_if.rd_busy[7]), 64'h0);
        check("post_rst_r11", 64'(rdd(2)), 64'h0);
        check("post_rst_conflict", 64'(rf_if.wr_conflict), 64'h0);
        check("post_rst_conf_addr", 64'(rf_if.conflict_addr), 64'h0);
        tick();
        check("post_rst_conflict_2", 64'(rf_if.wr_conflict), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
